// File: rtl/alu_flag_reg.sv
// ALU result register with valid/ready handshake and an 8080-style PSW flag register.
// Flags update per-bit under imask on an accept; POP PSW load and STC/CMC override in priority order.
module alu_flag_reg #(
  parameter int DATASIZE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATASIZE-1:0] iS,
  input  logic [DATASIZE-1:0] iC,
  input  logic                isub,
  input  logic [4:0]          imask,
  input  logic                ivalid,
  output logic                oready,
  input  logic                iload,
  input  logic [DATASIZE-1:0] ibus,
  input  logic                istc,
  input  logic                icmc,
  output logic [DATASIZE-1:0] odata,
  output logic [DATASIZE-1:0] oflag,
  output logic                ovalid,
  input  logic                iready
);

  function automatic logic even_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  logic [DATASIZE-1:0] r_data;
  logic                r_valid;
  logic                r_s, r_z, r_ac, r_p, r_cy;
  logic                w_accept;
  logic                w_s_alu, w_z_alu, w_ac_alu, w_p_alu, w_cy_alu;
  logic                w_s_nxt, w_z_nxt, w_ac_nxt, w_p_nxt, w_cy_nxt;

  // Handshake: reset and PSW load both stall the ALU path
  always_comb begin
    oready   = ~rst & ~iload & (~r_valid | iready);
    w_accept = ivalid & oready;
  end

  // Raw flag values from the incoming sum; subtract inverts the borrow sense
  always_comb begin
    w_s_alu  = iS[7];
    w_z_alu  = (iS == 8'h00);
    w_ac_alu = iC[3] ^ isub;
    w_p_alu  = even_parity(iS[7:0]);
    w_cy_alu = iC[7] ^ isub;
  end

  // Next-flag selection: load, then STC/CMC on carry, then masked ALU update
  always_comb begin
    w_s_nxt  = (w_accept & imask[4]) ? w_s_alu  : r_s;
    w_z_nxt  = (w_accept & imask[3]) ? w_z_alu  : r_z;
    w_ac_nxt = (w_accept & imask[2]) ? w_ac_alu : r_ac;
    w_p_nxt  = (w_accept & imask[1]) ? w_p_alu  : r_p;
    w_cy_nxt = r_cy;
    if (iload) begin
      w_s_nxt  = ibus[7];
      w_z_nxt  = ibus[6];
      w_ac_nxt = ibus[4];
      w_p_nxt  = ibus[2];
      w_cy_nxt = ibus[0];
    end else if (istc) begin
      w_cy_nxt = 1'b1;
    end else if (icmc) begin
      w_cy_nxt = ~r_cy;
    end else if (w_accept & imask[0]) begin
      w_cy_nxt = w_cy_alu;
    end else begin
      w_cy_nxt = r_cy;
    end
  end

  // Flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s  <= 1'b0;
      r_z  <= 1'b0;
      r_ac <= 1'b0;
      r_p  <= 1'b0;
      r_cy <= 1'b0;
    end else begin
      r_s  <= w_s_nxt;
      r_z  <= w_z_nxt;
      r_ac <= w_ac_nxt;
      r_p  <= w_p_nxt;
      r_cy <= w_cy_nxt;
    end
  end

  // Result register: accept wins over drain, otherwise hold under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= {DATASIZE{1'b0}};
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_data  <= iS;
      r_valid <= 1'b1;
    end else if (r_valid & iready) begin
      r_valid <= 1'b0;
    end else begin
      r_data  <= r_data;
      r_valid <= r_valid;
    end
  end

  assign odata  = r_data;
  assign ovalid = r_valid;
  assign oflag  = {r_s, r_z, 1'b0, r_ac, 1'b0, r_p, 1'b1, r_cy};

endmodule

// File: tb/tb_alu_flag_reg.sv
// Directed self-checking bench for alu_flag_reg; expected values are hand-computed PSW bytes.
module tb_alu_flag_reg;

  logic       clk;
  logic       rst;
  logic [7:0] iS, iC, ibus, odata, oflag;
  logic       isub, ivalid, oready, iload, istc, icmc, ovalid, iready;
  logic [4:0] imask;

  int n_chk;
  int n_err;

  alu_flag_reg #(.DATASIZE(8)) dut (
    .clk(clk), .rst(rst), .iS(iS), .iC(iC), .isub(isub), .imask(imask),
    .ivalid(ivalid), .oready(oready), .iload(iload), .ibus(ibus),
    .istc(istc), .icmc(icmc), .odata(odata), .oflag(oflag),
    .ovalid(ovalid), .iready(iready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst = 1'b1; iS = 8'h00; iC = 8'h00; ibus = 8'h00; isub = 1'b0;
    imask = 5'h00; ivalid = 1'b0; iload = 1'b0; istc = 1'b0; icmc = 1'b0; iready = 1'b1;

    // reset held two cycles
    step(); step();
    chk("rst_oflag", oflag, 8'h02);
    chk("rst_ovalid", {7'd0, ovalid}, 8'h00);
    chk("rst_odata", odata, 8'h00);
    chk("rst_oready", {7'd0, oready}, 8'h00);
    rst = 1'b0; #1;
    chk("post_rst_oready", {7'd0, oready}, 8'h01);

    // ADD 7F+01
    iS = 8'h80; iC = 8'h7F; isub = 1'b0; imask = 5'h1F; ivalid = 1'b1;
    step();
    chk("add7f_odata", odata, 8'h80);
    chk("add7f_oflag", oflag, 8'h92);
    chk("add7f_ovalid", {7'd0, ovalid}, 8'h01);

    // ADD FF+01, accepted while draining previous result
    iS = 8'h00; iC = 8'hFF;
    step();
    chk("addff_oflag", oflag, 8'h57);
    chk("addff_odata", odata, 8'h00);
    chk("addff_ovalid", {7'd0, ovalid}, 8'h01);

    // masked add leaves CY alone
    iS = 8'h01; iC = 8'h00; imask = 5'h1E;
    step();
    chk("mask_oflag", oflag, 8'h03);
    ivalid = 1'b0;
    step();
    chk("drain_ovalid", {7'd0, ovalid}, 8'h00);

    // SUB 05-05, then STC / CMC / both
    iS = 8'h00; iC = 8'hFF; isub = 1'b1; imask = 5'h1F; ivalid = 1'b1;
    step();
    chk("sub_oflag", oflag, 8'h46);
    ivalid = 1'b0; isub = 1'b0; istc = 1'b1;
    step();
    chk("stc_oflag", oflag, 8'h47);
    istc = 1'b0; icmc = 1'b1;
    step();
    chk("cmc_oflag", oflag, 8'h46);
    istc = 1'b1;
    step();
    chk("stc_wins_oflag", oflag, 8'h47);
    icmc = 1'b0;

    // STC alongside a full-mask accept: carry set, others from ALU
    iS = 8'h80; iC = 8'h00; imask = 5'h1F; ivalid = 1'b1;
    step();
    chk("stc_acc_oflag", oflag, 8'h83);
    chk("stc_acc_odata", odata, 8'h80);
    istc = 1'b0; ivalid = 1'b0;
    step();

    // backpressure
    iready = 1'b0; imask = 5'h00; iS = 8'h11; ivalid = 1'b1;
    step();
    chk("bp_first_odata", odata, 8'h11);
    chk("bp_oready", {7'd0, oready}, 8'h00);
    iS = 8'h22;
    step();
    chk("bp_hold_odata", odata, 8'h11);
    chk("bp_hold_ovalid", {7'd0, ovalid}, 8'h01);
    iready = 1'b1; #1;
    chk("bp_release_oready", {7'd0, oready}, 8'h01);
    step();
    chk("bp_second_odata", odata, 8'h22);
    chk("bp_second_ovalid", {7'd0, ovalid}, 8'h01);
    chk("bp_flags_held", oflag, 8'h83);
    ivalid = 1'b0;
    step();

    // PSW load blocks accept
    iload = 1'b1; ibus = 8'hFF; ivalid = 1'b1; iS = 8'h33; #1;
    chk("load_oready", {7'd0, oready}, 8'h00);
    step();
    chk("load_ff_oflag", oflag, 8'hD7);
    chk("load_no_accept", {7'd0, ovalid}, 8'h00);
    chk("load_odata_held", odata, 8'h22);
    ibus = 8'h00;
    step();
    chk("load_00_oflag", oflag, 8'h02);
    iload = 1'b0; ivalid = 1'b0;

    // reset in mid-handshake discards pending data
    iready = 1'b0; iS = 8'h44; ivalid = 1'b1;
    step();
    chk("pend_ovalid", {7'd0, ovalid}, 8'h01);
    rst = 1'b1;
    step();
    chk("mid_rst_ovalid", {7'd0, ovalid}, 8'h00);
    chk("mid_rst_odata", odata, 8'h00);
    chk("mid_rst_oflag", oflag, 8'h02);
    rst = 1'b0; #1;
    chk("mid_rst_oready", {7'd0, oready}, 8'h01);
    step();
    chk("after_rst_odata", odata, 8'h44);
    ivalid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
